change_dispenser: RTL and testbench

Coin payout unit on the change path of the vending machine. It accepts a change amount in cents from the vending FSM and pays it out by pulsing three coin-ejector solenoids: dollar, fifty and quarter. Coins are chosen largest-first, subject to per-coin inventory. The block reports completion, or a fault together with the unpaid remainder.

---
 rtl/vending_pkg.sv | 43 ++++
 rtl/coin_inventory.sv | 47 ++++
 rtl/change_dispenser.sv | 207 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending change path: coin values, select and
// fault encodings, and the change_dispenser state enum.
package vending_pkg;

  localparam logic [7:0] COIN_QUARTER = 8'd25;
  localparam logic [7:0] COIN_FIFTY   = 8'd50;
  localparam logic [7:0] COIN_DOLLAR  = 8'd100;

  // Same encoding as refill_sel; SEL_NONE doubles as the "ignored" refill code
  typedef enum logic [1:0] {
    SEL_QUARTER = 2'd0,
    SEL_FIFTY   = 2'd1,
    SEL_DOLLAR  = 2'd2,
    SEL_NONE    = 2'd3
  } coin_sel_t;

  typedef enum logic [1:0] {
    FC_NONE       = 2'd0,
    FC_SHORT      = 2'd1,
    FC_JAM        = 2'd2,
    FC_BAD_AMOUNT = 2'd3
  } fault_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_WAIT_SENSE,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_t;

  function automatic logic [7:0] coin_value(input coin_sel_t sel);
    case (sel)
      SEL_QUARTER: coin_value = COIN_QUARTER;
      SEL_FIFTY:   coin_value = COIN_FIFTY;
      SEL_DOLLAR:  coin_value = COIN_DOLLAR;
      default:     coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-coin inventory counters: reset to INIT_COUNT, overwrite on refill,
// decrement by one when the dispenser confirms a coin of that type.
module coin_inventory
  import vending_pkg::*;
#(
  parameter int INV_WIDTH  = 8,
  parameter int INIT_COUNT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 refill_en,
  input  logic [1:0]           refill_sel,
  input  logic [INV_WIDTH-1:0] refill_count,
  input  logic                 dec_en,
  input  coin_sel_t            dec_sel,
  output logic [INV_WIDTH-1:0] inv_quarter,
  output logic [INV_WIDTH-1:0] inv_fifty,
  output logic [INV_WIDTH-1:0] inv_dollar
);

  localparam logic [INV_WIDTH-1:0] INIT_VAL = INV_WIDTH'(INIT_COUNT);
  localparam logic [INV_WIDTH-1:0] ONE      = INV_WIDTH'(1);

  // Refill is only enabled in IDLE and decrement only in WAIT_SENSE, so they never collide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_quarter <= INIT_VAL;
      inv_fifty   <= INIT_VAL;
      inv_dollar  <= INIT_VAL;
    end else if (refill_en) begin
      case (refill_sel)
        2'd0:    inv_quarter <= refill_count;
        2'd1:    inv_fifty   <= refill_count;
        2'd2:    inv_dollar  <= refill_count;
        default: ;
      endcase
    end else if (dec_en) begin
      case (dec_sel)
        SEL_QUARTER: inv_quarter <= inv_quarter - ONE;
        SEL_FIFTY:   inv_fifty   <= inv_fifty - ONE;
        SEL_DOLLAR:  inv_dollar  <= inv_dollar - ONE;
        default:     ;
      endcase
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Coin payout FSM: pays change largest-coin-first via three ejector solenoids.
// Define CHANGE_DISPENSER_SENSE_EN to require coin_sensed confirmation (JAM timeout).
//
// state       | meaning
// IDLE        | ready for a request, refill allowed
// SELECT      | pick next coin or finish/fault
// PULSE       | selected solenoid driven for PULSE_CYCLES
// WAIT_SENSE  | wait for exit-sensor confirmation
// GAP         | mandatory idle between coins
// DONE        | one-cycle completion pulse
// FAULT       | one-cycle fault pulse, code latched
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int SENSE_TIMEOUT = 16,
  parameter int INV_WIDTH     = 8,
  parameter int INIT_COUNT    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 change_valid,
  input  logic [7:0]           change_amount,
  output logic                 change_ready,
  output logic                 eject_dollar,
  output logic                 eject_fifty,
  output logic                 eject_quarter,
  input  logic                 coin_sensed,
  input  logic                 refill,
  input  logic [1:0]           refill_sel,
  input  logic [INV_WIDTH-1:0] refill_count,
  output logic                 done,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [7:0]           remaining,
  output logic [INV_WIDTH-1:0] inv_quarter,
  output logic [INV_WIDTH-1:0] inv_fifty,
  output logic [INV_WIDTH-1:0] inv_dollar
);

  localparam int TW = 16;

  state_t      state, state_next;
  logic [TW-1:0] timer, timer_next;
  coin_sel_t   coin_sel, sel_next, pick;
  fault_code_t fc_q, fc_next;
  logic [7:0]  rem_q, rem_next;
  logic [2:0]  eject_q, eject_next;
  logic        dec_en;

`ifdef CHANGE_DISPENSER_SENSE_EN
  logic sensed, sensed_next;
`else
  logic          unused_sense;
  logic [TW-1:0] unused_timeout;
  assign unused_sense   = coin_sensed;
  assign unused_timeout = TW'(SENSE_TIMEOUT);
`endif

  coin_inventory #(
    .INV_WIDTH (INV_WIDTH),
    .INIT_COUNT(INIT_COUNT)
  ) u_inv (
    .clk         (clk),
    .reset       (reset),
    .refill_en   (refill && (state == ST_IDLE)),
    .refill_sel  (refill_sel),
    .refill_count(refill_count),
    .dec_en      (dec_en),
    .dec_sel     (coin_sel),
    .inv_quarter (inv_quarter),
    .inv_fifty   (inv_fifty),
    .inv_dollar  (inv_dollar)
  );

  always_comb begin
    pick = SEL_NONE;
    if (rem_q >= COIN_DOLLAR && inv_dollar != '0)        pick = SEL_DOLLAR;
    else if (rem_q >= COIN_FIFTY && inv_fifty != '0)     pick = SEL_FIFTY;
    else if (rem_q >= COIN_QUARTER && inv_quarter != '0) pick = SEL_QUARTER;
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    sel_next   = coin_sel;
    fc_next    = fc_q;
    rem_next   = rem_q;
    dec_en     = 1'b0;
`ifdef CHANGE_DISPENSER_SENSE_EN
    sensed_next = sensed;
`endif
    case (state)
      ST_IDLE: begin
        if (change_valid) begin
          rem_next   = change_amount;
          fc_next    = FC_NONE;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick != SEL_NONE) begin
          sel_next   = pick;
          timer_next = TW'(PULSE_CYCLES - 1);
          state_next = ST_PULSE;
`ifdef CHANGE_DISPENSER_SENSE_EN
          sensed_next = 1'b0;
`endif
        end else if (rem_q == 8'd0) begin
          state_next = ST_DONE;
        end else if (rem_q < COIN_QUARTER) begin
          fc_next    = FC_BAD_AMOUNT;
          state_next = ST_FAULT;
        end else begin
          fc_next    = FC_SHORT;
          state_next = ST_FAULT;
        end
      end
      ST_PULSE: begin
`ifdef CHANGE_DISPENSER_SENSE_EN
        if (coin_sensed) sensed_next = 1'b1;
`endif
        if (timer == '0) begin
          timer_next = TW'(SENSE_TIMEOUT - 1);
          state_next = ST_WAIT_SENSE;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      ST_WAIT_SENSE: begin
`ifdef CHANGE_DISPENSER_SENSE_EN
        if (sensed || coin_sensed) begin
          rem_next   = rem_q - coin_value(coin_sel);
          dec_en     = 1'b1;
          timer_next = TW'(GAP_CYCLES - 1);
          state_next = ST_GAP;
        end else if (timer == '0) begin
          fc_next    = FC_JAM;
          state_next = ST_FAULT;
        end else begin
          timer_next = timer - 1'b1;
        end
`else
        rem_next   = rem_q - coin_value(coin_sel);
        dec_en     = 1'b1;
        timer_next = TW'(GAP_CYCLES - 1);
        state_next = ST_GAP;
`endif
      end
      ST_GAP: begin
        if (timer == '0) state_next = ST_SELECT;
        else             timer_next = timer - 1'b1;
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Solenoid drive is registered off the next state so it is glitch-free
  always_comb begin
    eject_next = 3'b000;
    if (state_next == ST_PULSE) begin
      case (sel_next)
        SEL_QUARTER: eject_next = 3'b001;
        SEL_FIFTY:   eject_next = 3'b010;
        SEL_DOLLAR:  eject_next = 3'b100;
        default:     eject_next = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      coin_sel <= SEL_NONE;
      fc_q     <= FC_NONE;
      rem_q    <= 8'd0;
      eject_q  <= 3'b000;
`ifdef CHANGE_DISPENSER_SENSE_EN
      sensed   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      coin_sel <= sel_next;
      fc_q     <= fc_next;
      rem_q    <= rem_next;
      eject_q  <= eject_next;
`ifdef CHANGE_DISPENSER_SENSE_EN
      sensed   <= sensed_next;
`endif
    end
  end

  assign change_ready  = (state == ST_IDLE);
  assign done          = (state == ST_DONE);
  assign fault         = (state == ST_FAULT);
  assign fault_code    = fc_q;
  assign remaining     = rem_q;
  assign eject_quarter = eject_q[0];
  assign eject_fifty   = eject_q[1];
  assign eject_dollar  = eject_q[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed payouts, refill corner cases,
// zero-amount timing, JAM timeout (sense build) and mid-pulse reset.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       change_valid = 1'b0;
  logic [7:0] change_amount = 8'd0;
  logic       change_ready;
  logic       eject_dollar, eject_fifty, eject_quarter;
  logic       coin_sensed = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_sel = 2'd0;
  logic [7:0] refill_count = 8'd0;
  logic       done, fault;
  logic [1:0] fault_code;
  logic [7:0] remaining;
  logic [7:0] inv_quarter, inv_fifty, inv_dollar;

  change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .change_ready (change_ready),
    .eject_dollar (eject_dollar),
    .eject_fifty  (eject_fifty),
    .eject_quarter(eject_quarter),
    .coin_sensed  (coin_sensed),
    .refill       (refill),
    .refill_sel   (refill_sel),
    .refill_count (refill_count),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .remaining    (remaining),
    .inv_quarter  (inv_quarter),
    .inv_fifty    (inv_fifty),
    .inv_dollar   (inv_dollar)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_fault;
    int code;
    int rem;
    int iq;
    int ifi;
    int id;
  } exp_t;

  localparam logic [2:0] Q = 3'b001, F = 3'b010, D = 3'b100;

  exp_t       exp_q[$];
  logic [2:0] coin_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  sensor_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_resp(input bit f, input int code, input int rem,
                             input int iq, input int ifi, input int id);
    exp_t e;
    e.is_fault = f; e.code = code; e.rem = rem;
    e.iq = iq; e.ifi = ifi; e.id = id;
    exp_q.push_back(e);
  endtask

  // Response monitor: compares each done/fault against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (done || fault)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_fault", int'(fault), int'(e.is_fault));
          chk("resp_done", int'(done), int'(!e.is_fault));
          chk("fault_code", int'(fault_code), e.code);
          chk("remaining", int'(remaining), e.rem);
          chk("inv_quarter", int'(inv_quarter), e.iq);
          chk("inv_fifty", int'(inv_fifty), e.ifi);
          chk("inv_dollar", int'(inv_dollar), e.id);
        end
      end
    end
  end

  // Eject monitor: coin order and pulse width
  initial begin
    logic [2:0] prev, cur, ex;
    int width;
    prev = 3'b000;
    width = 0;
    forever begin
      @(negedge clk);
      cur = {eject_dollar, eject_fifty, eject_quarter};
      if (!reset) begin
        prev = 3'b000;
        width = 0;
      end else begin
        if (cur != 3'b000 && prev == 3'b000) begin
          if (coin_q.size() == 0) begin
            chk("unexpected_eject", int'(cur), 0);
          end else begin
            ex = coin_q.pop_front();
            chk("eject_coin", int'(cur), int'(ex));
          end
          width = 1;
        end else if (cur != 3'b000) begin
          width++;
        end else if (prev != 3'b000) begin
          chk("pulse_width", width, 4);
        end
        prev = cur;
      end
    end
  end

  // Exit-sensor model: one pulse during the solenoid pulse, plus a stray extra
  initial begin
    logic prev_any;
    prev_any = 1'b0;
    forever begin
      @(negedge clk);
      if (sensor_en && reset && (eject_dollar | eject_fifty | eject_quarter) && !prev_any) begin
        coin_sensed = 1'b1;
        @(negedge clk);
        coin_sensed = 1'b0;
        @(negedge clk);
        coin_sensed = 1'b1;
        @(negedge clk);
        coin_sensed = 1'b0;
      end
      prev_any = eject_dollar | eject_fifty | eject_quarter;
    end
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (change_ready) break;
    end
    if (i == 200) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_refill(input logic [1:0] sel, input logic [7:0] cnt);
    wait_ready();
    refill = 1'b1; refill_sel = sel; refill_count = cnt;
    @(negedge clk);
    refill = 1'b0;
  endtask

  task automatic accept(input logic [7:0] amt);
    wait_ready();
    change_valid = 1'b1;
    change_amount = amt;
    @(posedge clk);
    #1 change_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done || fault) break;
    end
    if (i == 400) chk("resp_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(change_ready), 1);
    chk("rst_ejects", int'({eject_dollar, eject_fifty, eject_quarter}), 0);
    chk("rst_done_fault", int'({done, fault}), 0);
    chk("rst_fault_code", int'(fault_code), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_inv", int'(inv_quarter) + int'(inv_fifty) + int'(inv_dollar), 30);
    reset = 1'b1;
    @(negedge clk);

    // 175 -> dollar, fifty, quarter
    coin_q.push_back(D); coin_q.push_back(F); coin_q.push_back(Q);
    expect_resp(0, 0, 0, 9, 9, 9);
    accept(8'd175);
    wait_resp();

    // No dollars: 100 -> two fifties
    do_refill(2'd2, 8'd0);
    coin_q.push_back(F); coin_q.push_back(F);
    expect_resp(0, 0, 0, 9, 7, 0);
    accept(8'd100);
    wait_resp();

    // Short on inventory
    do_refill(2'd0, 8'd1);
    do_refill(2'd1, 8'd0);
    coin_q.push_back(Q);
    expect_resp(1, 1, 50, 0, 0, 0);
    accept(8'd75);
    wait_resp();
    repeat (3) @(negedge clk);
    chk("rem_held_short", int'(remaining), 50);
    chk("code_held_short", int'(fault_code), 1);

    // refill_sel 3 is ignored; then restock quarters
    do_refill(2'd3, 8'd77);
    do_refill(2'd0, 8'd10);
    coin_q.push_back(Q);
    expect_resp(1, 3, 5, 9, 0, 0);
    accept(8'd30);
    wait_resp();

    // Zero amount: done at T+2, ready again at T+3, no ejects
    expect_resp(0, 0, 0, 9, 0, 0);
    accept(8'd0);
    @(negedge clk);
    chk("zero_ready_low", int'(change_ready), 0);
    chk("zero_done_t1", int'(done), 0);
    @(negedge clk);
    chk("zero_done_t2", int'(done), 1);
    @(negedge clk);
    chk("zero_ready_t3", int'(change_ready), 1);

    // Refill+accept in the same cycle; mid-payout refill/valid ignored
    wait_ready();
    coin_q.push_back(D);
    expect_resp(0, 0, 0, 9, 0, 0);
    refill = 1'b1; refill_sel = 2'd2; refill_count = 8'd1;
    change_valid = 1'b1; change_amount = 8'd100;
    @(posedge clk);
    #1 refill = 1'b0; change_valid = 1'b0;
    repeat (3) @(negedge clk);
    refill = 1'b1; refill_sel = 2'd0; refill_count = 8'd0;
    change_valid = 1'b1; change_amount = 8'd50;
    @(negedge clk);
    refill = 1'b0; change_valid = 1'b0;
    wait_resp();

`ifdef CHANGE_DISPENSER_SENSE_EN
    // JAM: no sensor pulse
    begin
      int lowc;
      int i;
      sensor_en = 1'b0;
      coin_q.push_back(Q);
      expect_resp(1, 2, 25, 9, 0, 0);
      accept(8'd25);
      for (i = 0; i < 20; i++) begin
        @(negedge clk);
        if (eject_quarter) break;
      end
      while (eject_quarter && i < 40) begin
        @(negedge clk);
        i++;
      end
      lowc = 0;
      while (!fault && lowc < 40) begin
        lowc++;
        @(negedge clk);
      end
      chk("jam_delay", lowc, 16);
      @(negedge clk);
      sensor_en = 1'b1;
    end
`endif

    // Async reset mid-pulse during a dollar payout
    begin
      int i;
      do_refill(2'd2, 8'd5);
      coin_q.push_back(D);
      accept(8'd100);
      for (i = 0; i < 20; i++) begin
        @(negedge clk);
        if (eject_dollar) break;
      end
      chk("reset_pulse_seen", int'(eject_dollar), 1);
      #2 reset = 1'b0;
      #1 chk("reset_eject_drop", int'(eject_dollar), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", int'(change_ready), 1);
      chk("post_rst_remaining", int'(remaining), 0);
      chk("post_rst_inv_q", int'(inv_quarter), 10);
      chk("post_rst_inv_f", int'(inv_fifty), 10);
      chk("post_rst_inv_d", int'(inv_dollar), 10);
    end

    repeat (10) @(negedge clk);
    chk("pending_responses", exp_q.size(), 0);
    chk("pending_coins", coin_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
